reg_alu_seq: RTL and testbench

Command sequencer for the 8x8 register-file/ALU datapath (`reg_alu`). It accepts register commands over a valid/ready interface and buffers them in a 4-entry FIFO. It drives the datapath control pins one command at a time, latches the ALU carry, and returns register read data over a valid/ready response port. It sits between the queue front-end and one `reg_alu` instance, and is the only driver of that instance's control inputs.

---
 rtl/reg_alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_reg_alu_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_seq.sv
// Command sequencer for the reg_alu register-file/ALU datapath: buffers commands in a
// 4-entry FIFO, issues them one at a time, latches the ALU carry and returns READ data.
module reg_alu_seq (
    input  logic       clk,
    input  logic       reset,
    // command port
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    input  logic [2:0] cmd_dst,
    input  logic [7:0] cmd_imm,
    // datapath control
    output logic       dp_sel,
    output logic       dp_wr,
    output logic [1:0] dp_op,
    output logic [2:0] dp_rd_addr_a,
    output logic [2:0] dp_rd_addr_b,
    output logic [2:0] dp_wr_addr,
    output logic [7:0] dp_d_in,
    input  logic [7:0] dp_d_out_a,
    input  logic [7:0] dp_d_out_b,
    input  logic       dp_cout,
    // response port and status
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data_a,
    output logic [7:0] rsp_data_b,
    output logic       carry_flag,
    output logic       busy
);

    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_ALU  = 2'b01,
        CMD_READ = 2'b10,
        CMD_NOP  = 2'b11
    } cmd_kind_e;

    typedef struct packed {
        cmd_kind_e  kind;
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] dst;
        logic [7:0] imm;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLAG,
        S_RESP
    } state_e;

    cmd_t       fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    cmd_t       cur;
    state_e     state;
    state_e     state_next;
    logic       push;
    logic       pop;

    assign cmd_ready = (count != FIFO_DEPTH) && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (count != 3'd0);

    // NOTE: FIFO storage has no reset; an entry is only ever read after it was written,
    // so flushing the pointers and count is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{kind: cmd_kind_e'(cmd_type), op: cmd_op, a: cmd_a,
                                  b: cmd_b, dst: cmd_dst, imm: cmd_imm};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cur   <= '0;
        end else begin
            state <= state_next;
            if (pop) cur <= fifo_mem[rd_ptr];
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (count != 3'd0) state_next = S_ISSUE;
            S_ISSUE: begin
                case (cur.kind)
                    CMD_ALU:  state_next = S_FLAG;
                    CMD_READ: state_next = S_RESP;
                    default:  state_next = S_IDLE;
                endcase
            end
            S_FLAG:  state_next = S_IDLE;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath pins are driven only in ISSUE; reset overrides so no write can land
    // in the reset cycle even if the old state is still ISSUE.
    always_comb begin
        dp_sel       = 1'b0;
        dp_wr        = 1'b0;
        dp_op        = 2'b00;
        dp_rd_addr_a = 3'd0;
        dp_rd_addr_b = 3'd0;
        dp_wr_addr   = 3'd0;
        dp_d_in      = 8'h00;
        if (state == S_ISSUE && !reset) begin
            case (cur.kind)
                CMD_LOAD: begin
                    dp_wr      = 1'b1;
                    dp_wr_addr = cur.dst;
                    dp_d_in    = cur.imm;
                end
                CMD_ALU: begin
                    dp_sel       = 1'b1;
                    dp_wr        = 1'b1;
                    dp_op        = cur.op;
                    dp_rd_addr_a = cur.a;
                    dp_rd_addr_b = cur.b;
                    dp_wr_addr   = cur.dst;
                end
                CMD_READ: begin
                    dp_rd_addr_a = cur.a;
                    dp_rd_addr_b = cur.b;
                end
                default: ;
            endcase
        end
    end

    // The datapath carry is registered, so it is valid in FLAG, one cycle after the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_flag <= 1'b0;
            rsp_data_a <= 8'h00;
            rsp_data_b <= 8'h00;
        end else begin
            if (state == S_FLAG) carry_flag <= dp_cout;
            if (state == S_ISSUE && cur.kind == CMD_READ) begin
                rsp_data_a <= dp_d_out_a;
                rsp_data_b <= dp_d_out_b;
            end
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign busy      = (count != 3'd0) || (state != S_IDLE);

endmodule

// File: tb/tb_reg_alu_seq.sv
// Directed bench for reg_alu_seq with a behavioural reg_alu datapath attached.
module tb_reg_alu_seq;

    localparam logic [1:0] T_LOAD = 2'b00;
    localparam logic [1:0] T_ALU  = 2'b01;
    localparam logic [1:0] T_READ = 2'b10;
    localparam logic [1:0] T_NOP  = 2'b11;
    localparam logic [1:0] OP_ADD = 2'b00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = '0;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_a = '0;
    logic [2:0] cmd_b = '0;
    logic [2:0] cmd_dst = '0;
    logic [7:0] cmd_imm = '0;
    logic       dp_sel;
    logic       dp_wr;
    logic [1:0] dp_op;
    logic [2:0] dp_rd_addr_a;
    logic [2:0] dp_rd_addr_b;
    logic [2:0] dp_wr_addr;
    logic [7:0] dp_d_in;
    logic [7:0] dp_d_out_a;
    logic [7:0] dp_d_out_b;
    logic       dp_cout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data_a;
    logic [7:0] rsp_data_b;
    logic       carry_flag;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_alu_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .dp_sel(dp_sel), .dp_wr(dp_wr), .dp_op(dp_op),
        .dp_rd_addr_a(dp_rd_addr_a), .dp_rd_addr_b(dp_rd_addr_b), .dp_wr_addr(dp_wr_addr),
        .dp_d_in(dp_d_in), .dp_d_out_a(dp_d_out_a), .dp_d_out_b(dp_d_out_b), .dp_cout(dp_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
        .carry_flag(carry_flag), .busy(busy)
    );

    // Behavioural reg_alu: 8x8 register file, op 00 add / 01 sub / 10 and / 11 or,
    // carry registered on ALU writes.
    logic [7:0] rf [8];
    logic       cout_r;
    logic [8:0] alu_res;

    assign dp_d_out_a = rf[dp_rd_addr_a];
    assign dp_d_out_b = rf[dp_rd_addr_b];
    assign dp_cout    = cout_r;

    always_comb begin
        case (dp_op)
            2'b00:   alu_res = {1'b0, dp_d_out_a} + {1'b0, dp_d_out_b};
            2'b01:   alu_res = {1'b0, dp_d_out_a} - {1'b0, dp_d_out_b};
            2'b10:   alu_res = {1'b0, dp_d_out_a & dp_d_out_b};
            default: alu_res = {1'b0, dp_d_out_a | dp_d_out_b};
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
            cout_r <= 1'b0;
        end else if (dp_wr) begin
            if (dp_sel) begin
                rf[dp_wr_addr] <= alu_res[7:0];
                cout_r         <= alu_res[8];
            end else begin
                rf[dp_wr_addr] <= dp_d_in;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic push(input logic [1:0] t, input logic [1:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] dst, input logic [7:0] imm);
        int n = 0;
        cmd_type = t; cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = dst; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", rsp_valid, 1);
    endtask

    task automatic read_rsp(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        wait_rsp();
        check({tag, "_a"}, rsp_data_a, ea);
        check({tag, "_b"}, rsp_data_b, eb);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_dp_wr", dp_wr, 0);
        check("rst_rsp_data", {rsp_data_a, rsp_data_b}, 0);
        reset = 1'b0;
        #1 check("post_rst_ready", cmd_ready, 1);

        // LOAD r3 <= 5A with cycle-exact issue, then READ 3,3
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd3, 8'h5A);
        check("load_pop_cycle_wr", dp_wr, 0);
        check("load_busy", busy, 1);
        @(negedge clk);
        check("load_issue", {dp_wr, dp_sel, dp_wr_addr, dp_d_in}, {1'b1, 1'b0, 3'd3, 8'h5A});
        @(negedge clk);
        check("load_done_wr", dp_wr, 0);
        check("load_done_busy", busy, 0);
        push(T_READ, 2'b00, 3'd3, 3'd3, 3'd0, 8'h00);
        check("read_c1_valid", rsp_valid, 0);
        @(negedge clk);
        check("read_c2_valid", rsp_valid, 0);
        check("read_c2_addr", {dp_wr, dp_rd_addr_a, dp_rd_addr_b}, {1'b0, 3'd3, 3'd3});
        @(negedge clk);
        check("read_c3_valid", rsp_valid, 1);
        read_rsp("read_r3", 8'h5A, 8'h5A);
        check("read_r3_carry", carry_flag, 0);

        // F0 + 20 -> 10 with carry
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd1, 8'hF0);
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd2, 8'h20);
        push(T_ALU, OP_ADD, 3'd1, 3'd2, 3'd4, 8'h00);
        begin
            int n = 0;
            while (!(dp_wr && dp_sel) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("alu_issue", {dp_wr, dp_sel, dp_op, dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr},
              {1'b1, 1'b1, OP_ADD, 3'd1, 3'd2, 3'd4});
        check("alu_issue_carry", carry_flag, 0);
        @(negedge clk);
        check("alu_flag_carry", carry_flag, 0);
        check("alu_flag_dp_wr", dp_wr, 0);
        @(negedge clk);
        check("alu_after_carry", carry_flag, 1);
        push(T_READ, 2'b00, 3'd4, 3'd4, 3'd0, 8'h00);
        read_rsp("read_r4", 8'h10, 8'h10);

        // fill the FIFO behind a stalled READ
        push(T_READ, 2'b00, 3'd1, 3'd2, 3'd0, 8'h00);
        wait_rsp();
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd6, 8'h11);
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd7, 8'h22);
        push(T_READ, 2'b00, 3'd6, 3'd7, 3'd0, 8'h00);
        push(T_NOP, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00);
        check("full_ready", cmd_ready, 0);
        cmd_type = T_READ; cmd_a = 3'd1; cmd_b = 3'd1; cmd_valid = 1'b1;
        @(negedge clk);
        check("full_held_ready", cmd_ready, 0);
        read_rsp("read_r1r2", 8'hF0, 8'h20);
        check("full_after_hs_ready", cmd_ready, 0);
        push(T_READ, 2'b00, 3'd1, 3'd1, 3'd0, 8'h00);
        read_rsp("order_r6r7", 8'h11, 8'h22);
        read_rsp("fifth_r1", 8'hF0, 8'hF0);
        wait_idle();

        // READ stalled 5 cycles with a LOAD waiting behind it
        push(T_READ, 2'b00, 3'd6, 3'd6, 3'd0, 8'h00);
        wait_rsp();
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd0, 8'h33);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {rsp_valid, busy, dp_wr, rsp_data_a, rsp_data_b},
                  {1'b1, 1'b1, 1'b0, 8'h11, 8'h11});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall_hs_idle_wr", {rsp_valid, dp_wr}, 0);
        @(negedge clk);
        check("stall_next_issue", {dp_wr, dp_wr_addr, dp_d_in}, {1'b1, 3'd0, 8'h33});
        wait_idle();

        // clear carry (33+33=66), then r5 = 81+81 = 02 with carry
        push(T_ALU, OP_ADD, 3'd0, 3'd0, 3'd0, 8'h00);
        wait_idle();
        check("carry_cleared", carry_flag, 0);
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd5, 8'h81);
        push(T_ALU, OP_ADD, 3'd5, 3'd5, 3'd5, 8'h00);
        push(T_READ, 2'b00, 3'd5, 3'd5, 3'd0, 8'h00);
        read_rsp("read_r5", 8'h02, 8'h02);
        check("r5_carry", carry_flag, 1);

        // reset during RESP with two commands queued
        push(T_READ, 2'b00, 3'd5, 3'd5, 3'd0, 8'h00);
        wait_rsp();
        push(T_LOAD, 2'b00, 3'd0, 3'd0, 3'd1, 8'hAA);
        push(T_ALU, OP_ADD, 3'd1, 3'd1, 3'd2, 8'h00);
        reset = 1'b1;
        #1 check("mid_rst_dp_wr", dp_wr, 0);
        check("mid_rst_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("mid_rst_after", {rsp_valid, busy, carry_flag, cmd_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        check("mid_rst_no_wr", {dp_wr, busy}, 0);
        for (int r = 0; r < 8; r++) begin
            push(T_READ, 2'b00, 3'(r), 3'(r), 3'd0, 8'h00);
            read_rsp($sformatf("flushed_r%0d", r), 8'h00, 8'h00);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
